// File: rtl/instruction_memory_pkg.sv
// Shared RISC-V core constants: data width, canonical NOP and the boot image
// that the instruction store loads on reset.
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam int BOOT_LEN = 4;

  // Minimal boot program: x1 = 5, x2 = 10, x3 = x1 + x2, store x3 to address 0.
  localparam logic [XLEN-1:0] BOOT_IMAGE [BOOT_LEN] = '{
    32'h0050_0093,  // addi x1,x0,5
    32'h00A0_0113,  // addi x2,x0,10
    32'h0020_81B3,  // add  x3,x1,x2
    32'h0030_2023   // sw   x3,0(x0)
  };

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch and program-load signals between the core and the instruction store.
interface instruction_memory_if;
  import rv_pkg::*;

  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] instr;
  logic            addr_misaligned;
  logic            addr_out_of_range;
  logic            we;
  logic [XLEN-1:0] waddr;
  logic [XLEN-1:0] wdata;

  // Core / loader side: drives addresses and write data, observes the fetch.
  modport master (
    output addr, we, waddr, wdata,
    input  instr, addr_misaligned, addr_out_of_range
  );

  // Memory side.
  modport slave (
    input  addr, we, waddr, wdata,
    output instr, addr_misaligned, addr_out_of_range
  );

endinterface

// File: rtl/instruction_memory_addr_decode.sv
// Byte address to word index decode for the instruction store. Pure
// combinational; used once for the fetch port and once for the write port.
module imem_addr_decode
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int              DEPTH     = 256,
  parameter int              IDX_W     = $clog2(DEPTH)
) (
  input  logic [XLEN-1:0] addr,
  output logic [IDX_W-1:0] index,
  output logic             misaligned,
  output logic             out_of_range
);

  // Work in word units so the low two address bits never enter the index math.
  localparam logic [XLEN-3:0] BASE_WORD = BASE_ADDR[XLEN-1:2];
  localparam logic [XLEN-3:0] DEPTH_W   = (XLEN-2)'(DEPTH);

  logic [XLEN-3:0] word_off;
  logic            below_base;

  // Offset from the base word, range check without wrap-around, and alignment.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    word_off     = addr[XLEN-1:2] - BASE_WORD;
    below_base   = addr[XLEN-1:2] < BASE_WORD;
    out_of_range = below_base || (word_off >= DEPTH_W);
    index        = word_off[IDX_W-1:0];
    misaligned   = |addr[1:0];
  end

endmodule

// File: rtl/instruction_memory.sv
// Word-organised instruction store for the single-cycle core. Combinational
// fetch, synchronous program-load write, and a synchronous reset that restores
// the boot image into the whole array.
module instruction_memory
  import rv_pkg::*;
#(
  parameter int              DEPTH     = 256,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_WORD  = NOP_INSTR
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_memory_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  logic [IDX_W-1:0] r_index;
  logic             r_misaligned;
  logic             r_out_of_range;

  logic [IDX_W-1:0] w_index;
  logic             w_out_of_range;
  // Program-load writes ignore the low address bits, so alignment is not used.
  logic             w_misaligned_unused;

  imem_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_fetch_decode (
    .addr         (bus.addr),
    .index        (r_index),
    .misaligned   (r_misaligned),
    .out_of_range (r_out_of_range)
  );

  imem_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_write_decode (
    .addr         (bus.waddr),
    .index        (w_index),
    .misaligned   (w_misaligned_unused),
    .out_of_range (w_out_of_range)
  );

  // Boot-image load on reset (wins over a concurrent write), else program load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this array is deliberately reset -- the boot image is its
      // functional reset value. That forces flop storage rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= NOP_WORD;
      end
      // Later non-blocking assignments to the same word override the NOP fill.
      for (int j = 0; j < BOOT_LEN; j++) begin
        mem[j] <= BOOT_IMAGE[j];
      end
    end else if (bus.we && !w_out_of_range) begin
      mem[w_index] <= bus.wdata;
    end
  end

  // Fetch path: no clock, no bypass of an in-flight write, NOP outside the map.
  always_comb begin
    bus.instr             = r_out_of_range ? NOP_WORD : mem[r_index];
    bus.addr_misaligned   = r_misaligned;
    bus.addr_out_of_range = r_out_of_range;
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory. Stimulus pushes the expected fetch
// result into a scoreboard queue; a monitor process pops and compares it.
module tb_instruction_memory;

  logic clk;
  logic rst_n;

  instruction_memory_if bus ();

  instruction_memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        mis;
    logic        oor;
  } exp_t;

  exp_t exp_q[$];
  event push_ev;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare the DUT fetch outputs against each expected entry.
  initial begin
    exp_t e;
    forever begin
      @(push_ev);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.instr !== e.instr || bus.addr_misaligned !== e.mis ||
            bus.addr_out_of_range !== e.oor) begin
          errors++;
          $display("FAIL %s addr=%h: got instr=%h mis=%b oor=%b, want instr=%h mis=%b oor=%b",
                   e.name, e.addr, bus.instr, bus.addr_misaligned, bus.addr_out_of_range,
                   e.instr, e.mis, e.oor);
        end
      end
    end
  end

  // Drive a fetch address, then hand the expected response to the monitor.
  task automatic expect_fetch(input string name, input logic [31:0] a,
                              input logic [31:0] ins, input logic mis, input logic oor);
    exp_t e;
    bus.addr = a;
    #1;
    e.name  = name;
    e.addr  = a;
    e.instr = ins;
    e.mis   = mis;
    e.oor   = oor;
    exp_q.push_back(e);
    ->push_ev;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: monitor did not consume entry, queue size %0d, want 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;

    // 1. One reset edge, then the boot image is visible combinationally.
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_fetch("boot_w0", 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    #9 expect_fetch("boot_w1", 32'h4, 32'h00A0_0113, 1'b0, 1'b0);
    #9 expect_fetch("boot_w2", 32'h8, 32'h0020_81B3, 1'b0, 1'b0);
    #9 expect_fetch("boot_w3", 32'hC, 32'h0030_2023, 1'b0, 1'b0);

    // 2. NOP fill and range boundaries.
    expect_fetch("nop_fill",   32'h10,        32'h0000_0013, 1'b0, 1'b0);
    expect_fetch("last_word",  32'h3FC,       32'h0000_0013, 1'b0, 1'b0);
    expect_fetch("oor_top",    32'h400,       32'h0000_0013, 1'b0, 1'b1);
    expect_fetch("oor_far",    32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 1'b1);
    expect_fetch("oor_mis",    32'h401,       32'h0000_0013, 1'b1, 1'b1);

    // 3. Misaligned fetches return the truncated-address word.
    expect_fetch("mis_6", 32'h6, 32'h00A0_0113, 1'b1, 1'b0);
    expect_fetch("mis_3", 32'h3, 32'h0050_0093, 1'b1, 1'b0);

    // 4. Program-load write: old value before the edge, new value after.
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = 32'h8;
    bus.wdata = 32'hDEAD_BEEF;
    expect_fetch("wr_before", 32'h8, 32'h0020_81B3, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.we = 1'b0;
    expect_fetch("wr_after", 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Misaligned write address lands on the truncated word.
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = 32'hE;
    bus.wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 bus.we = 1'b0;
    expect_fetch("wr_mis_addr", 32'hC, 32'hCAFE_F00D, 1'b0, 1'b0);

    // Write to the last in-range word.
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = 32'h3FC;
    bus.wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 bus.we = 1'b0;
    expect_fetch("wr_last", 32'h3FC, 32'hA5A5_A5A5, 1'b0, 1'b0);

    // Out-of-range write is dropped: nothing changes, no wrap into word 0.
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = 32'h400;
    bus.wdata = 32'h1111_1111;
    @(posedge clk);
    #1 bus.we = 1'b0;
    expect_fetch("oor_wr_w0",   32'h0,   32'h0050_0093, 1'b0, 1'b0);
    expect_fetch("oor_wr_w1",   32'h4,   32'h00A0_0113, 1'b0, 1'b0);
    expect_fetch("oor_wr_w2",   32'h8,   32'hDEAD_BEEF, 1'b0, 1'b0);
    expect_fetch("oor_wr_w3",   32'hC,   32'hCAFE_F00D, 1'b0, 1'b0);
    expect_fetch("oor_wr_w4",   32'h10,  32'h0000_0013, 1'b0, 1'b0);
    expect_fetch("oor_wr_last", 32'h3FC, 32'hA5A5_A5A5, 1'b0, 1'b0);
    expect_fetch("oor_wr_top",  32'h400, 32'h0000_0013, 1'b0, 1'b1);

    // 5. Reset beats a simultaneous write and restores the full image.
    @(negedge clk);
    rst_n     = 1'b0;
    bus.we    = 1'b1;
    bus.waddr = 32'h0;
    bus.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    rst_n  = 1'b1;
    expect_fetch("rst_w0",   32'h0,   32'h0050_0093, 1'b0, 1'b0);
    expect_fetch("rst_w2",   32'h8,   32'h0020_81B3, 1'b0, 1'b0);
    expect_fetch("rst_w3",   32'hC,   32'h0030_2023, 1'b0, 1'b0);
    expect_fetch("rst_last", 32'h3FC, 32'h0000_0013, 1'b0, 1'b0);

    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
